// File: rtl/sobel_pkg.sv
// sobel_pkg: shared pixel/window types and counter width helper for the Sobel window generator
package sobel_pkg;
    localparam int PIX_W = 8;
    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [2:0][2:0] window_t;
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one-line RAM, shared read/write address, old data visible while writing
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 16,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    assign rdata = mem[addr];
    // write lands at the edge, so the same-cycle read still returns the previous line
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: turns a raster pixel stream into 3x3 neighbourhoods for the gradient core
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_sof,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] p00,
    output logic [DATA_WIDTH-1:0] p01,
    output logic [DATA_WIDTH-1:0] p02,
    output logic [DATA_WIDTH-1:0] p10,
    output logic [DATA_WIDTH-1:0] p11,
    output logic [DATA_WIDTH-1:0] p12,
    output logic [DATA_WIDTH-1:0] p20,
    output logic [DATA_WIDTH-1:0] p21,
    output logic [DATA_WIDTH-1:0] p22,
    output logic                  m_last
);
    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col, c_pos;
    logic [RW-1:0] row, r_pos;
    logic accept, emit, frame_end;
    logic [2*DATA_WIDTH-1:0] lb_rd, lb_wr;
    logic [2:0][2:0][DATA_WIDTH-1:0] win;

    assign s_ready   = !m_valid || m_ready;
    assign accept    = s_valid && s_ready;
    assign c_pos     = s_sof ? '0 : col;
    assign r_pos     = s_sof ? '0 : row;
    assign emit      = (r_pos >= ROW_TWO) && (c_pos >= COL_TWO);
    assign frame_end = (r_pos == ROW_LAST) && (c_pos == COL_LAST);
    // upper half holds row r-2 (lb1), lower half row r-1 (lb0); both age by one line per write
    assign lb_wr     = {lb_rd[DATA_WIDTH-1:0], s_data};

    sobel_line_buffer #(
        .DEPTH(IMG_WIDTH),
        .WIDTH(2 * DATA_WIDTH),
        .AW   (CW)
    ) u_lb (
        .clk  (clk),
        .we   (accept),
        .addr (c_pos),
        .wdata(lb_wr),
        .rdata(lb_rd)
    );

    assign {p00, p01, p02} = {win[0][0], win[0][1], win[0][2]};
    assign {p10, p11, p12} = {win[1][0], win[1][1], win[1][2]};
    assign {p20, p21, p22} = {win[2][0], win[2][1], win[2][2]};

    // raster position of the next pixel; sof restarts the frame at the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            col <= (c_pos == COL_LAST) ? '0 : c_pos + 1'b1;
            row <= (c_pos != COL_LAST) ? r_pos : (r_pos == ROW_LAST) ? '0 : r_pos + 1'b1;
        end
    end

    // 3x3 shift window: columns move left, newest column comes from the buffers and the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb_rd[2*DATA_WIDTH-1:DATA_WIDTH];
            win[1][2] <= lb_rd[DATA_WIDTH-1:0];
            win[2][2] <= s_data;
        end
    end

    // single output stage: a window is valid after any beat that completes an interior 3x3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (accept) begin
            m_valid <= emit;
            m_last  <= emit && frame_end;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: randomized stream bench with a frame-image reference model
module tb_sobel_window_gen;
    localparam int W = 5;
    localparam int H = 4;
    localparam int BW = 40;
    localparam int BH = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b1;
    logic [7:0] s_data = '0;
    logic s_ready, m_valid, m_last;
    logic [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;

    logic b_valid = 1'b0, b_sof = 1'b0, b_mready = 1'b1;
    logic [7:0] b_data = '0;
    logic b_ready, b_mvalid, b_mlast;
    logic [71:0] b_win;

    always #5 clk = ~clk;

    sobel_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .m_valid(m_valid), .m_ready(m_ready),
        .p00(p00), .p01(p01), .p02(p02), .p10(p10), .p11(p11), .p12(p12),
        .p20(p20), .p21(p21), .p22(p22), .m_last(m_last)
    );

    sobel_window_gen #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH)) dut_big (
        .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
        .s_sof(b_sof), .m_valid(b_mvalid), .m_ready(b_mready),
        .p00(b_win[71:64]), .p01(b_win[63:56]), .p02(b_win[55:48]),
        .p10(b_win[47:40]), .p11(b_win[39:32]), .p12(b_win[31:24]),
        .p20(b_win[23:16]), .p21(b_win[15:8]), .p22(b_win[7:0]), .m_last(b_mlast)
    );

    wire [71:0] win_o = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

    int total = 0, bad = 0;
    int gap_pct = 0, stall_pct = 0, stall_left = 0, npop = 0;
    int mr = 0, mc = 0;
    logic [7:0] img [H][W];
    logic [72:0] exp_q [$];
    logic [72:0] obs [$];
    logic held = 1'b0;
    logic [72:0] hold_w;

    task automatic chk(input string tag, input logic [72:0] got, input logic [72:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference: remember the latest value at every frame position, emit interior windows
    task automatic model_accept(input logic [7:0] d, input logic sof);
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = d;
        if (mr >= 2 && mc >= 2)
            exp_q.push_back({(mr == H - 1 && mc == W - 1) ? 1'b1 : 1'b0,
                             img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                             img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                             img[mr][mc-2], img[mr][mc-1], img[mr][mc]});
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end
    endtask

    task automatic set_ready();
        if (stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
        end else if ($urandom_range(0, 99) < stall_pct) begin
            stall_left = $urandom_range(1, 5) - 1;
            m_ready = 1'b0;
        end else m_ready = 1'b1;
    endtask

    // one clock: observe at the falling edge, then return just after the rising edge
    task automatic step(output logic acc);
        logic [72:0] e;
        @(negedge clk);
        if (m_valid && m_ready) begin
            npop++;
            obs.push_back({m_last, win_o});
            if (exp_q.size() == 0) chk("unexpected_window", {m_last, win_o}, '0);
            else begin
                e = exp_q.pop_front();
                chk("window", {m_last, win_o}, e);
            end
        end
        if (m_valid && !m_ready) begin
            chk("stall_ready", {72'd0, s_ready}, 73'd0);
            if (held) chk("stall_stable", {m_last, win_o}, hold_w);
            hold_w = {m_last, win_o};
            held = 1'b1;
        end else held = 1'b0;
        acc = s_valid && s_ready;
        if (acc) model_accept(s_data, s_sof);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pixel(input logic [7:0] d, input logic sof);
        logic acc;
        int n;
        n = 0;
        do begin
            s_valid = ($urandom_range(0, 99) >= gap_pct);
            s_data = d;
            s_sof = sof;
            set_ready();
            step(acc);
            n++;
        end while (!acc && n < 300);
        if (!acc) chk("accept_timeout", 73'd0, 73'd1);
        s_valid = 1'b0;
        s_sof = 1'b0;
    endtask

    task automatic drive_pixels(input int count, input int ramp, input logic sof_first);
        for (int i = 0; i < count; i++)
            drive_pixel(ramp != 0 ? 8'((i / W) * 5 + i % W) : 8'($urandom_range(0, 255)),
                        sof_first && i == 0);
    endtask

    task automatic drain_check(input string tag, input int nexp);
        logic acc;
        s_valid = 1'b0;
        stall_left = 0;
        m_ready = 1'b1;
        repeat (3) step(acc);
        chk({tag, "_count"}, 73'(npop), 73'(nexp));
        chk({tag, "_leftover"}, 73'(exp_q.size()), 73'd0);
        npop = 0;
    endtask

    initial begin
        int nb, nl, last_at, nrdy;
        #12;
        chk("reset_valid", {72'd0, m_valid}, 73'd0);
        chk("reset_last", {72'd0, m_last}, 73'd0);
        chk("reset_window", {1'b0, win_o}, 73'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_ready", {72'd0, s_ready}, 73'd1);

        // full-rate ramp frame
        obs.delete();
        drive_pixels(W * H, 1, 1'b1);
        drain_check("ramp", 6);
        if (obs.size() == 6) begin
            chk("ramp_first", obs[0], {1'b0, 8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});
            chk("ramp_last", obs[5], {1'b1, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19});
        end else chk("ramp_obs", 73'(obs.size()), 73'd6);

        // downstream stalls
        stall_pct = 40;
        drive_pixels(W * H, 0, 1'b1);
        drain_check("stall", 6);

        // three back-to-back frames
        stall_pct = 20;
        repeat (3) drive_pixels(W * H, 0, 1'b1);
        drain_check("b2b", 18);

        // sof at natural (2,3) restarts the frame
        stall_pct = 0;
        drive_pixels(13, 0, 1'b1);
        drive_pixels(W * H, 0, 1'b1);
        drain_check("sof_mid", 7);

        // asynchronous reset while a window is pending
        drive_pixels(13, 0, 1'b1);
        s_valid = 1'b0;
        m_ready = 1'b0;
        #2;
        chk("pre_reset_valid", {72'd0, m_valid}, 73'd1);
        rst_n = 1'b0;
        #1;
        chk("async_valid", {72'd0, m_valid}, 73'd0);
        chk("async_last", {72'd0, m_last}, 73'd0);
        exp_q.delete();
        mr = 0;
        mc = 0;
        held = 1'b0;
        npop = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_pixels(W * H, 0, 1'b0);
        drain_check("post_reset", 6);

        // input gaps with stalls
        gap_pct = 30;
        stall_pct = 20;
        drive_pixels(W * H, 0, 1'b1);
        drain_check("gaps", 6);

        // larger frame at full rate
        nb = 0;
        nl = 0;
        last_at = 0;
        nrdy = 0;
        b_valid = 1'b1;
        b_mready = 1'b1;
        for (int i = 0; i < BW * BH + 3; i++) begin
            b_valid = (i < BW * BH);
            b_data = 8'($urandom_range(0, 255));
            b_sof = (i == 0);
            @(negedge clk);
            if (b_valid && !b_ready) nrdy++;
            if (b_mvalid) begin
                nb++;
                if (b_mlast) begin
                    nl++;
                    last_at = nb;
                end
            end
            @(posedge clk);
            #1;
        end
        b_valid = 1'b0;
        chk("big_count", 73'(nb), 73'((BW - 2) * (BH - 2)));
        chk("big_lasts", 73'(nl), 73'd1);
        chk("big_last_pos", 73'(last_at), 73'((BW - 2) * (BH - 2)));
        chk("big_full_rate", 73'(nrdy), 73'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
